// File: rtl/mmio_pkg.sv
// mmio_pkg: constant address map, bridge state encoding and a window-match
// helper shared by the MMIO bridge and its address decoder.
package mmio_pkg;

   localparam int MAX_SLV = 8;
   localparam int INT_SLV = 2;

   // Unused entries have base above limit so they can never match.
   localparam logic [31:0] SLV_BASE [0:7] = '{
      32'h0000_0000,
      32'h0000_7F00,
      32'h0000_7F20,
      32'hFFFF_FFFF,
      32'hFFFF_FFFF,
      32'hFFFF_FFFF,
      32'hFFFF_FFFF,
      32'hFFFF_FFFF
   };

   localparam logic [31:0] SLV_LIMIT [0:7] = '{
      32'h0000_2FFF,
      32'h0000_7F0B,
      32'h0000_7F23,
      32'h0000_0000,
      32'h0000_0000,
      32'h0000_0000,
      32'h0000_0000,
      32'h0000_0000
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } bridge_state_t;

   function automatic logic in_window(input logic [31:0] addr, input int idx);
      return (addr >= SLV_BASE[idx]) && (addr <= SLV_LIMIT[idx]);
   endfunction

endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: combinational address decoder. Produces a hit flag, a one-hot
// slave select and the binary slave index; the lowest matching index wins.
module mmio_decode
   import mmio_pkg::*;
#(
   parameter int N_SLV = 3
) (
   input  logic [31:0]      addr,
   output logic             hit,
   output logic [N_SLV-1:0] sel,
   output logic [2:0]       idx
);

   // Scan from the highest slave down so that a lower matching index overwrites.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      idx = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if (in_window(addr, i)) begin
            hit    = 1'b1;
            sel    = '0;
            sel[i] = 1'b1;
            idx    = 3'(i);
         end
      end
   end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU data port to N_SLV memory-mapped slaves. Decodes each access,
// holds a registered one-hot select plus address/data/byte-enables until the
// selected slave is ready, then returns registered read data with an error flag.
// Optional feature macro BRIDGE_TIMEOUT_EN: when defined, an access that sees no
// slave ready within TIMEOUT cycles ends in a bus error; otherwise ACCESS waits
// indefinitely.
module mmio_bridge
   import mmio_pkg::*;
#(
   parameter int N_SLV   = 3,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cpu_req,
   input  logic [31:0]             cpu_addr,
   input  logic [DATA_W-1:0]       cpu_wdata,
   input  logic [DATA_W/8-1:0]     cpu_byteen,
   output logic [DATA_W-1:0]       cpu_rdata,
   output logic                    cpu_ready,
   output logic                    cpu_err,
   output logic [N_SLV-1:0]        slv_sel,
   output logic [31:0]             slv_addr,
   output logic [DATA_W-1:0]       slv_wdata,
   output logic [DATA_W/8-1:0]     slv_byteen,
   input  logic [N_SLV*DATA_W-1:0] slv_rdata,
   input  logic [N_SLV-1:0]        slv_ready
);

   localparam int BE_W = DATA_W / 8;

   bridge_state_t state, state_next;

   logic             dec_hit;
   logic [N_SLV-1:0] dec_sel;
   logic [2:0]       dec_idx;

   logic              latch_req;
   logic              capture;
   logic              fail;
   logic [DATA_W-1:0] sel_rdata;
   logic              sel_ready;
   logic [BE_W-1:0]   byteen_eff;

`ifdef BRIDGE_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;
   logic             cnt_inc;
`endif

   mmio_decode #(
      .N_SLV (N_SLV)
   ) u_decode (
      .addr (cpu_addr),
      .hit  (dec_hit),
      .sel  (dec_sel),
      .idx  (dec_idx)
   );

   // Interrupt-generator writes are narrowed to the lowest byte lane only.
   always_comb begin
      byteen_eff = cpu_byteen;
      if (dec_idx == 3'(INT_SLV) && cpu_byteen != '0) begin
         byteen_eff = BE_W'(1);
      end
   end

   // Route the currently selected slave's read data and ready back to the FSM.
   always_comb begin
      sel_rdata = '0;
      sel_ready = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (slv_sel[i]) begin
            sel_rdata = slv_rdata[i*DATA_W +: DATA_W];
            sel_ready = slv_ready[i];
         end
      end
   end

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the datapath strobes that go with each transition.
   always_comb begin
      state_next = state;
      latch_req  = 1'b0;
      capture    = 1'b0;
      fail       = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_inc    = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (cpu_req) begin
               latch_req  = 1'b1;
               fail       = !dec_hit;
               state_next = dec_hit ? ST_ACCESS : ST_RESP;
            end
         end
         ST_ACCESS: begin
            if (sel_ready) begin
               capture    = 1'b1;
               state_next = ST_RESP;
            end
`ifdef BRIDGE_TIMEOUT_EN
            else if (cnt == CNT_W'(TIMEOUT)) begin
               fail       = 1'b1;
               state_next = ST_RESP;
            end else begin
               cnt_inc = 1'b1;
            end
`endif
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Request latch, slave select and response registers; select drops on exit from ACCESS.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slv_sel    <= '0;
         slv_addr   <= '0;
         slv_wdata  <= '0;
         slv_byteen <= '0;
         cpu_rdata  <= '0;
         cpu_err    <= 1'b0;
      end else begin
         if (latch_req) begin
            slv_addr   <= cpu_addr;
            slv_wdata  <= cpu_wdata;
            slv_byteen <= byteen_eff;
            slv_sel    <= dec_hit ? dec_sel : '0;
         end
         if (capture) begin
            cpu_rdata <= sel_rdata;
            cpu_err   <= 1'b0;
            slv_sel   <= '0;
         end
         if (fail) begin
            cpu_rdata <= '0;
            cpu_err   <= 1'b1;
            slv_sel   <= '0;
         end
      end
   end

`ifdef BRIDGE_TIMEOUT_EN
   // Wait-cycle counter: cleared when an access is launched, counts ACCESS cycles without ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (latch_req) begin
         cnt <= '0;
      end else if (cnt_inc) begin
         cnt <= cnt + 1'b1;
      end
   end
`endif

   assign cpu_ready = (state == ST_RESP);

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed plus randomized checks of mmio_bridge against an
// address-map reference model (N_SLV=3, DATA_W=32, TIMEOUT=15). The timeout
// step follows BRIDGE_TIMEOUT_EN the same way the design does.
module tb_mmio_bridge;

   localparam int N_SLV  = 3;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   logic                    clk;
   logic                    reset_n;
   logic                    cpu_req;
   logic [31:0]             cpu_addr;
   logic [DATA_W-1:0]       cpu_wdata;
   logic [BE_W-1:0]         cpu_byteen;
   logic [DATA_W-1:0]       cpu_rdata;
   logic                    cpu_ready;
   logic                    cpu_err;
   logic [N_SLV-1:0]        slv_sel;
   logic [31:0]             slv_addr;
   logic [DATA_W-1:0]       slv_wdata;
   logic [BE_W-1:0]         slv_byteen;
   logic [N_SLV*DATA_W-1:0] slv_rdata;
   logic [N_SLV-1:0]        slv_ready;

   int total = 0;
   int bad   = 0;

   mmio_bridge #(
      .N_SLV   (N_SLV),
      .DATA_W  (DATA_W),
      .TIMEOUT (15)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_byteen (cpu_byteen),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .cpu_err    (cpu_err),
      .slv_sel    (slv_sel),
      .slv_addr   (slv_addr),
      .slv_wdata  (slv_wdata),
      .slv_byteen (slv_byteen),
      .slv_rdata  (slv_rdata),
      .slv_ready  (slv_ready)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference address map: data memory 12 KiB at 0, timer 12 bytes at 0x7F00,
   // interrupt generator 4 bytes at 0x7F20; anything else is unmapped.
   function automatic int ref_target(input logic [31:0] a);
      if (a < 32'd12288) return 0;
      if (a >= 32'h7F00 && a - 32'h7F00 < 32'd12) return 1;
      if (a >= 32'h7F20 && a - 32'h7F20 < 32'd4) return 2;
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One complete CPU access; the selected slave answers after 'waits' idle cycles
   // while the other slaves assert ready with junk data that must be ignored.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int waits, input logic [31:0] rd);
      int         tgt;
      logic [2:0] onehot;
      logic [3:0] exp_be;
      tgt = ref_target(addr);
      @(negedge clk);
      cpu_req    = 1'b1;
      cpu_addr   = addr;
      cpu_wdata  = wdata;
      cpu_byteen = be;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      if (tgt < 0) begin
         checkOutput("unmapped_sel", 64'(slv_sel), 64'd0);
         checkOutput("unmapped_ready", 64'(cpu_ready), 64'd1);
         checkOutput("unmapped_err", 64'(cpu_err), 64'd1);
      end else begin
         onehot = 3'b001 << tgt;
         exp_be = (tgt == 2 && be != 4'd0) ? 4'b0001 : be;
         checkOutput("sel", 64'(slv_sel), 64'(onehot));
         checkOutput("addr", 64'(slv_addr), 64'(addr));
         checkOutput("wdata", 64'(slv_wdata), 64'(wdata));
         checkOutput("byteen", 64'(slv_byteen), 64'(exp_be));
         for (int w = 0; w < waits; w++) begin
            slv_ready = ~onehot;
            slv_rdata = {$urandom, $urandom, $urandom};
            @(negedge clk);
            checkOutput("wait_ready", 64'(cpu_ready), 64'd0);
            checkOutput("wait_sel", 64'(slv_sel), 64'(onehot));
         end
         slv_ready = onehot;
         slv_rdata = {$urandom, $urandom, $urandom};
         slv_rdata[tgt*DATA_W +: DATA_W] = rd;
         @(negedge clk);
         slv_ready = '0;
         checkOutput("done_ready", 64'(cpu_ready), 64'd1);
         checkOutput("done_err", 64'(cpu_err), 64'd0);
         checkOutput("done_rdata", 64'(cpu_rdata), 64'(rd));
         checkOutput("done_sel", 64'(slv_sel), 64'd0);
      end
      @(negedge clk);
      checkOutput("ready_pulse_end", 64'(cpu_ready), 64'd0);
      if (tgt >= 0) begin
         checkOutput("rdata_hold", 64'(cpu_rdata), 64'(rd));
      end
   endtask

   initial begin
      logic [31:0] edges [7];
      logic [31:0] a;
      int          r;
      edges = '{32'h0000_2FFF, 32'h0000_3000, 32'h0000_7EFF, 32'h0000_7F0C,
                32'h0000_7F1F, 32'h0000_7F24, 32'hFFFF_FFFF};

      reset_n    = 1'b0;
      cpu_req    = 1'b0;
      cpu_addr   = '0;
      cpu_wdata  = '0;
      cpu_byteen = '0;
      slv_rdata  = '0;
      slv_ready  = '0;

      // Reset state.
      #3;
      checkOutput("rst_ready", 64'(cpu_ready), 64'd0);
      checkOutput("rst_err", 64'(cpu_err), 64'd0);
      checkOutput("rst_sel", 64'(slv_sel), 64'd0);
      checkOutput("rst_rdata", 64'(cpu_rdata), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed accesses from the plan.
      applyStimulus(32'h0000_1004, 32'h1111_2222, 4'b0000, 0, 32'hDEAD_BEEF);
      applyStimulus(32'h0000_7F04, 32'hCAFE_F00D, 4'b1111, 3, 32'h0BAD_CAFE);
      applyStimulus(32'h0000_7F20, 32'h0000_00A5, 4'b1111, 0, 32'h5555_AAAA);
      applyStimulus(32'h0000_7F20, 32'h0000_0000, 4'b0000, 1, 32'h0000_0007);
      applyStimulus(32'h0000_5000, 32'h0, 4'b0000, 0, 32'h0);

      // Request held high: ignored in RESP, accepted again in the following IDLE.
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_addr = 32'h0000_5000;
      cpu_byteen = 4'b0000;
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_first", 64'(cpu_ready), 64'd1);
      @(negedge clk);
      checkOutput("b2b_gap", 64'(cpu_ready), 64'd0);
      @(negedge clk);
      checkOutput("b2b_second", 64'(cpu_ready), 64'd1);
      cpu_req = 1'b0;
      @(negedge clk);
      checkOutput("b2b_idle", 64'(cpu_ready), 64'd0);

      // Timer that never answers.
      @(negedge clk);
      cpu_req    = 1'b1;
      cpu_addr   = 32'h0000_7F04;
      cpu_wdata  = 32'h1234_5678;
      cpu_byteen = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      checkOutput("to_sel", 64'(slv_sel), 64'b010);
`ifdef BRIDGE_TIMEOUT_EN
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         checkOutput("to_wait", 64'(cpu_ready), 64'd0);
      end
      @(negedge clk);
      checkOutput("to_ready", 64'(cpu_ready), 64'd1);
      checkOutput("to_err", 64'(cpu_err), 64'd1);
      checkOutput("to_rdata", 64'(cpu_rdata), 64'd0);
      checkOutput("to_sel_drop", 64'(slv_sel), 64'd0);
`else
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checkOutput("nto_wait", 64'(cpu_ready), 64'd0);
         checkOutput("nto_sel", 64'(slv_sel), 64'b010);
      end
      slv_ready = 3'b010;
      slv_rdata = {32'h0, 32'h7777_1234, 32'h0};
      @(negedge clk);
      slv_ready = '0;
      checkOutput("nto_ready", 64'(cpu_ready), 64'd1);
      checkOutput("nto_err", 64'(cpu_err), 64'd0);
      checkOutput("nto_rdata", 64'(cpu_rdata), 64'h7777_1234);
`endif
      @(negedge clk);

      // Reset in the middle of an access.
      cpu_req    = 1'b1;
      cpu_addr   = 32'h0000_1004;
      cpu_byteen = 4'b0000;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      checkOutput("rsta_sel", 64'(slv_sel), 64'b001);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rsta_sel_drop", 64'(slv_sel), 64'd0);
      checkOutput("rsta_addr", 64'(slv_addr), 64'd0);
      checkOutput("rsta_ready", 64'(cpu_ready), 64'd0);
      checkOutput("rsta_err", 64'(cpu_err), 64'd0);
      @(negedge clk);
      reset_n   = 1'b1;
      slv_ready = 3'b001;
      slv_rdata = {3{32'hFEED_FACE}};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("rsta_late_ready", 64'(cpu_ready), 64'd0);
      end
      slv_ready = '0;

      // Randomized accesses across mapped windows, window edges and arbitrary addresses.
      for (int n = 0; n < 24; n++) begin
         r = $urandom_range(0, 4);
         case (r)
            0:       a = 32'($urandom_range(0, 32'h2FFF));
            1:       a = 32'h7F00 + 32'($urandom_range(0, 11));
            2:       a = 32'h7F20 + 32'($urandom_range(0, 3));
            3:       a = edges[$urandom_range(0, 6)];
            default: a = $urandom;
         endcase
         applyStimulus(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
